// File: rtl/controller.sv
// Multi-cycle Moore control unit for the 8-bit accumulator CPU: sequences
// fetch/decode/execute and drives every datapath strobe from state and op_q.
module controller (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] opcode,
   output logic       pcEn,
   output logic       selAddress,
   output logic       mr,
   output logic       mw,
   output logic       wordRegEn,
   output logic       LSEn,
   output logic       RSEn,
   output logic       DIEn,
   output logic       dataRegEn,
   output logic       resultRegEn,
   output logic       enb,
   output logic       CEn,
   output logic       ZEn,
   output logic       NEn,
   output logic [1:0] selData,
   output logic [1:0] selAddressAC,
   output logic       selALUsrc,
   output logic [2:0] operation,
   output logic       halted
);

   typedef enum logic [3:0] {
      FETCH1, DECODE, FETCH2, MEMRD, LDWB, ALU, ALUWB, RDAC, MEMWR, MOVWB, HALT
   } stateT;

   typedef enum logic [2:0] {
      LDA = 3'b000, STA = 3'b001, ADDA = 3'b010, SUBA = 3'b011,
      SDI = 3'b100, MOVR = 3'b101, NOP = 3'b110, HLT = 3'b111
   } opT;

   typedef struct packed {
      logic       pcEn;
      logic       selAddress;
      logic       mr;
      logic       mw;
      logic       wordRegEn;
      logic       LSEn;
      logic       RSEn;
      logic       DIEn;
      logic       dataRegEn;
      logic       resultRegEn;
      logic       enb;
      logic       CEn;
      logic       ZEn;
      logic       NEn;
      logic [1:0] selData;
      logic [1:0] selAddressAC;
      logic       selALUsrc;
      logic [2:0] operation;
      logic       halted;
   } ctrlT;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;

   stateT state, nextState;
   opT    opQ;
   ctrlT  ctrl, ctrlOut;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= FETCH1;
         opQ   <= LDA;
      end else begin
         state <= nextState;
         if (state == FETCH1) opQ <= opT'(opcode);
      end
   end

   // NOTE: every variable gets a default before the case so no path leaves
   // one unassigned, which would otherwise infer a latch.
   always_comb begin
      ctrl      = '0;
      nextState = state;
      case (state)
         FETCH1: begin
            ctrl.mr   = 1'b1;
            ctrl.LSEn = 1'b1;
            ctrl.pcEn = 1'b1;
            nextState = DECODE;
         end
         DECODE: begin
            case (opQ)
               LDA, STA, ADDA, SUBA: nextState = FETCH2;
               SDI: begin
                  ctrl.DIEn = 1'b1;
                  nextState = FETCH1;
               end
               MOVR: begin
                  ctrl.selAddressAC = 2'b01;
                  ctrl.operation    = ALU_AND;
                  ctrl.resultRegEn  = 1'b1;
                  nextState         = MOVWB;
               end
               NOP:     nextState = FETCH1;
               default: nextState = HALT;
            endcase
         end
         FETCH2: begin
            ctrl.mr   = 1'b1;
            ctrl.RSEn = 1'b1;
            ctrl.pcEn = 1'b1;
            nextState = (opQ == STA) ? RDAC : MEMRD;
         end
         MEMRD: begin
            ctrl.selAddress = 1'b1;
            ctrl.mr         = 1'b1;
            ctrl.wordRegEn  = 1'b1;
            nextState       = (opQ == LDA) ? LDWB : ALU;
         end
         LDWB: begin
            ctrl.enb  = 1'b1;
            nextState = FETCH1;
         end
         ALU: begin
            ctrl.selALUsrc   = 1'b1;
            ctrl.resultRegEn = 1'b1;
            ctrl.CEn         = 1'b1;
            ctrl.ZEn         = 1'b1;
            ctrl.NEn         = 1'b1;
            ctrl.operation   = (opQ == SUBA) ? ALU_SUB : ALU_ADD;
            nextState        = ALUWB;
         end
         ALUWB: begin
            ctrl.selData = 2'b01;
            ctrl.enb     = 1'b1;
            nextState    = FETCH1;
         end
         RDAC: begin
            ctrl.dataRegEn = 1'b1;
            nextState      = MEMWR;
         end
         MEMWR: begin
            ctrl.selAddress = 1'b1;
            ctrl.mw         = 1'b1;
            nextState       = FETCH1;
         end
         MOVWB: begin
            ctrl.selData      = 2'b01;
            ctrl.selAddressAC = 2'b10;
            ctrl.enb          = 1'b1;
            nextState         = FETCH1;
         end
         HALT: begin
            ctrl.halted = 1'b1;
            nextState   = HALT;
         end
         default: nextState = FETCH1;
      endcase
   end

   // The aborted instruction must emit nothing during the reset cycle itself.
   assign ctrlOut = reset ? '0 : ctrl;

   assign pcEn         = ctrlOut.pcEn;
   assign selAddress   = ctrlOut.selAddress;
   assign mr           = ctrlOut.mr;
   assign mw           = ctrlOut.mw;
   assign wordRegEn    = ctrlOut.wordRegEn;
   assign LSEn         = ctrlOut.LSEn;
   assign RSEn         = ctrlOut.RSEn;
   assign DIEn         = ctrlOut.DIEn;
   assign dataRegEn    = ctrlOut.dataRegEn;
   assign resultRegEn  = ctrlOut.resultRegEn;
   assign enb          = ctrlOut.enb;
   assign CEn          = ctrlOut.CEn;
   assign ZEn          = ctrlOut.ZEn;
   assign NEn          = ctrlOut.NEn;
   assign selData      = ctrlOut.selData;
   assign selAddressAC = ctrlOut.selAddressAC;
   assign selALUsrc    = ctrlOut.selALUsrc;
   assign operation    = ctrlOut.operation;
   assign halted       = ctrlOut.halted;

endmodule

// File: tb/tb_controller.sv
// Self-checking bench for controller: an instruction-level reference model
// (per-opcode strobe sequences in a queue) checked every cycle, plus literals.
module tb_controller;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [2:0] opcode = 3'b000;
   logic       pcEn, selAddress, mr, mw, wordRegEn, LSEn, RSEn, DIEn;
   logic       dataRegEn, resultRegEn, enb, CEn, ZEn, NEn, selALUsrc, halted;
   logic [1:0] selData, selAddressAC;
   logic [2:0] operation;

   controller dut (
      .clk(clk), .reset(reset), .opcode(opcode),
      .pcEn(pcEn), .selAddress(selAddress), .mr(mr), .mw(mw),
      .wordRegEn(wordRegEn), .LSEn(LSEn), .RSEn(RSEn), .DIEn(DIEn),
      .dataRegEn(dataRegEn), .resultRegEn(resultRegEn), .enb(enb),
      .CEn(CEn), .ZEn(ZEn), .NEn(NEn), .selData(selData),
      .selAddressAC(selAddressAC), .selALUsrc(selALUsrc),
      .operation(operation), .halted(halted)
   );

   always #5 clk = ~clk;

   // Strobe bit masks within the packed observation vector.
   localparam logic [22:0] HALTV  = 23'h1 << 0;
   localparam logic [22:0] OPSUB  = 23'h1 << 1;
   localparam logic [22:0] OPAND  = 23'h2 << 1;
   localparam logic [22:0] SRC    = 23'h1 << 4;
   localparam logic [22:0] ACLS10 = 23'h1 << 5;
   localparam logic [22:0] ACLS32 = 23'h2 << 5;
   localparam logic [22:0] SDRES  = 23'h1 << 7;
   localparam logic [22:0] NE     = 23'h1 << 9;
   localparam logic [22:0] ZE     = 23'h1 << 10;
   localparam logic [22:0] CE     = 23'h1 << 11;
   localparam logic [22:0] ENB    = 23'h1 << 12;
   localparam logic [22:0] RES    = 23'h1 << 13;
   localparam logic [22:0] DATA   = 23'h1 << 14;
   localparam logic [22:0] DIE    = 23'h1 << 15;
   localparam logic [22:0] RSE    = 23'h1 << 16;
   localparam logic [22:0] LSE    = 23'h1 << 17;
   localparam logic [22:0] WORD   = 23'h1 << 18;
   localparam logic [22:0] MW     = 23'h1 << 19;
   localparam logic [22:0] MR     = 23'h1 << 20;
   localparam logic [22:0] SADR   = 23'h1 << 21;
   localparam logic [22:0] PC     = 23'h1 << 22;

   localparam logic [22:0] FETCHV = MR | LSE | PC;
   localparam logic [22:0] ADDRV  = MR | RSE | PC;
   localparam logic [22:0] MEMRDV = SADR | MR | WORD;
   localparam logic [22:0] ALUV   = SRC | RES | CE | ZE | NE;

   logic [22:0] actVec;
   assign actVec = {pcEn, selAddress, mr, mw, wordRegEn, LSEn, RSEn, DIEn,
                    dataRegEn, resultRegEn, enb, CEn, ZEn, NEn, selData,
                    selAddressAC, selALUsrc, operation, halted};

   int nChecks = 0;
   int nPass = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act === exp) nPass++;
      else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
   endtask

   // Expected strobes for the cycles after FETCH1; empty queue means FETCH1.
   logic [22:0] expQ[$];

   function automatic void pushSeq(input logic [2:0] op);
      case (op)
         3'd0: begin expQ.push_back(0); expQ.push_back(ADDRV); expQ.push_back(MEMRDV);
                     expQ.push_back(ENB); end
         3'd1: begin expQ.push_back(0); expQ.push_back(ADDRV); expQ.push_back(DATA);
                     expQ.push_back(SADR | MW); end
         3'd2: begin expQ.push_back(0); expQ.push_back(ADDRV); expQ.push_back(MEMRDV);
                     expQ.push_back(ALUV); expQ.push_back(ENB | SDRES); end
         3'd3: begin expQ.push_back(0); expQ.push_back(ADDRV); expQ.push_back(MEMRDV);
                     expQ.push_back(ALUV | OPSUB); expQ.push_back(ENB | SDRES); end
         3'd4: expQ.push_back(DIE);
         3'd5: begin expQ.push_back(ACLS10 | OPAND | RES);
                     expQ.push_back(SDRES | ACLS32 | ENB); end
         3'd6: expQ.push_back(0);
         default: begin expQ.push_back(0); expQ.push_back(HALTV); end
      endcase
   endfunction

   always @(posedge clk) begin
      if (reset) expQ.delete();
      else if (expQ.size() == 0) pushSeq(opcode);
      else if (expQ[0] != HALTV) void'(expQ.pop_front());
   end

   always @(negedge clk) begin
      logic [22:0] expV;
      if (reset) expV = '0;
      else if (expQ.size() == 0) expV = FETCHV;
      else expV = expQ[0];
      check("strobes", {9'd0, actVec}, {9'd0, expV});
   end

   task automatic step(input logic r, input logic [2:0] op);
      @(posedge clk);
      #2;
      reset  = r;
      opcode = op;
   endtask

   task automatic runInstr(input logic [2:0] op, input int len, input logic [2:0] fill);
      step(1'b0, op);
      for (int i = 1; i < len; i++) step(1'b0, fill);
   endtask

   initial begin
      // Reset, then LDA with opcode 000 held.
      step(1'b1, 3'd0);
      step(1'b1, 3'd0);
      @(negedge clk);
      check("reset all zero", {9'd0, actVec}, 32'd0);
      step(1'b0, 3'd0); @(negedge clk); check("lda c1 pcEn", pcEn, 1);
      step(1'b0, 3'd0); @(negedge clk); check("lda c2 pcEn", pcEn, 0);
      step(1'b0, 3'd0); @(negedge clk); check("lda c3 pcEn", pcEn, 1);
      step(1'b0, 3'd0); @(negedge clk); check("lda c4 wordRegEn", wordRegEn, 1);
      step(1'b0, 3'd0); @(negedge clk); check("lda c5 enb/selData", {enb, selData}, 3'b100);
      step(1'b0, 3'd6); @(negedge clk); check("lda c6 fetch", {mr, LSEn}, 2'b11);
      step(1'b0, 3'd6);

      // ADDA then SUBA.
      runInstr(3'd2, 4, 3'd5);
      step(1'b0, 3'd5); @(negedge clk);
      check("adda alu op", {operation, selALUsrc, CEn, ZEn, NEn}, 7'b0001111);
      step(1'b0, 3'd5); @(negedge clk); check("adda wb selData", selData, 2'b01);
      runInstr(3'd3, 4, 3'd0);
      step(1'b0, 3'd0); @(negedge clk); check("suba alu op", operation, 3'b001);
      step(1'b0, 3'd0);

      // STA with opcode 111 on the address byte.
      runInstr(3'd1, 3, 3'd7);
      step(1'b0, 3'd7); @(negedge clk); check("sta rdac", dataRegEn, 1);
      step(1'b0, 3'd7); @(negedge clk); check("sta memwr", {mw, selAddress, mr}, 3'b110);

      // SDI, MOVR, NOP.
      runInstr(3'd4, 2, 3'd2);
      step(1'b0, 3'd5); @(negedge clk); check("movr fetch", mr, 1);
      step(1'b0, 3'd0); @(negedge clk); check("movr read", {selAddressAC, resultRegEn}, 3'b011);
      step(1'b0, 3'd0); @(negedge clk); check("movr wb", {selAddressAC, enb}, 3'b101);
      runInstr(3'd6, 2, 3'd7);

      // HLT with toggling opcode, then a single reset cycle.
      step(1'b0, 3'd7);
      step(1'b0, 3'd0);
      step(1'b0, 3'd3); @(negedge clk); check("hlt c3 halted", halted, 1);
      for (int i = 0; i < 22; i++) step(1'b0, 3'($urandom_range(0, 7)));
      @(negedge clk); check("halt sticky", {9'd0, actVec}, {9'd0, HALTV});
      step(1'b1, 3'd0);
      step(1'b0, 3'd6); @(negedge clk); check("post-halt fetch", {halted, mr}, 2'b01);
      step(1'b0, 3'd6);

      // Reset during the ALU cycle of ADDA.
      runInstr(3'd2, 4, 3'd7);
      step(1'b1, 3'd7); @(negedge clk); check("reset in alu", {9'd0, actVec}, 32'd0);
      step(1'b0, 3'd6); @(negedge clk); check("abort fetch", {mr, LSEn, enb}, 3'b110);
      step(1'b0, 3'd6); @(negedge clk); check("abort no wb", enb, 0);

      // Randomized opcode stream with occasional resets.
      for (int i = 0; i < 600; i++)
         step(($urandom_range(0, 39) == 0), 3'($urandom_range(0, 7)));

      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule

// File: doc/controller.md
# controller

Multi-cycle control unit for the 8-bit accumulator CPU datapath. It sequences instruction fetch, decode and execute, and drives every datapath control strobe. Its input is the 3-bit opcode taken from bits [7:5] of the memory read word. It is a Moore FSM with one internal opcode latch and a sticky halt state.

## Interface
- Parameters: none.
- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  synchronous, active-high; sampled on rising edge of clk
- opcode  input  3  memory read word bits [7:5]; valid while mr=1
- pcEn, selAddress, mr, mw  output  1 each  PC increment; address select (0 = PC, 1 = {LS[4:0],RS}); memory read; memory write
- wordRegEn, LSEn, RSEn, DIEn  output  1 each  load word, LS, RS and DI registers
- dataRegEn, resultRegEn, enb  output  1 each  load data register; load result register; accumulator write
- CEn, ZEn, NEn  output  1 each  flag register loads
- selData  output  2  accumulator write source (00 = word, 01 = result, 10 = data)
- selAddressAC  output  2  accumulator index (00 = DI[4:3], 01 = LS[1:0], 10 = LS[3:2])
- selALUsrc  output  1  ALU B operand (0 = accumulator, 1 = word register)
- operation  output  3  ALU function (000 ADD, 001 SUB, 010 AND)
- halted  output  1  high while in HALT

## Operation
- ISA: opcode 000 LDA, 001 STA, 010 ADDA, 011 SUBA. These are two-byte instructions with 13-bit address {LS[4:0],RS} and operate on AC[DI[4:3]].
- ISA: opcode 100 SDI (DI ← LS[4:0]), 101 MOVR (AC[LS[3:2]] ← AC[LS[1:0]]), 110 NOP, 111 HLT. These are one-byte instructions.
- Output rule: every output is 0 unless listed for the current state. Outputs depend only on the state and the latched opcode (op_q).
- FETCH1: mr, LSEn, pcEn (selAddress=0); op_q ← opcode. Next state is DECODE.
- DECODE, by op_q:
  - 000–011: no outputs; next state FETCH2.
  - 100: DIEn; next state FETCH1.
  - 101: selAddressAC=01, selALUsrc=0, operation=010, resultRegEn; next state MOVWB.
  - 110: no outputs; next state FETCH1.
  - 111: no outputs; next state HALT.
- FETCH2: mr, RSEn, pcEn. If op_q=001, next state RDAC; otherwise next state MEMRD.
- MEMRD: selAddress=1, mr, wordRegEn. If op_q=000, next state LDWB; otherwise next state ALU.
- LDWB: selData=00, selAddressAC=00, enb. Next state FETCH1.
- ALU: selAddressAC=00, selALUsrc=1, resultRegEn, CEn, ZEn, NEn; operation=000 for ADDA, 001 for SUBA. Next state ALUWB.
- ALUWB: selData=01, selAddressAC=00, enb. Next state FETCH1.
- RDAC: selAddressAC=00, dataRegEn. Next state MEMWR.
- MEMWR: selAddress=1, mw. Next state FETCH1.
- MOVWB: selData=01, selAddressAC=10, enb. Next state FETCH1.
- HALT: all strobes 0, halted=1. Remains in HALT until reset.
- mr and mw are never high in the same cycle. enb is never high in the same cycle as mr.

## Timing
- Reset behaviour:
  - While reset=1 at a clock edge: next state FETCH1, op_q=000.
  - Reset overrides any state, including HALT and mid-instruction; the aborted instruction leaves no further strobes.
  - During the reset cycle itself all outputs are forced to 0 combinationally. Reset values: every output 0, halted=0.
- Memory assumptions: reads are combinational within the mr cycle; writes commit at the clock edge ending the mw cycle.
- Cycles per instruction, FETCH1 to next FETCH1:
  - SDI, NOP: 2
  - MOVR: 3
  - LDA, STA: 5
  - ADDA, SUBA: 6
  - HLT: 2 to reach HALT
- pcEn pulses exactly once per fetched byte: once per one-byte instruction, twice per two-byte instruction.
- Opcode handling: opcode is sampled only in FETCH1 and ignored in all other states. The opcode input changing in FETCH2 (the address byte) must not affect sequencing.
- Flags are written only in the ALU state. LDA, STA and MOVR never assert CEn, ZEn or NEn.

## Test plan
- Reset, then opcode=000 held: states FETCH1, DECODE, FETCH2, MEMRD, LDWB. pcEn high in cycles 1 and 3; wordRegEn in cycle 4; enb with selData=00 in cycle 5; cycle 6 is FETCH1.
- ADDA then SUBA: in the ALU cycle, operation=000 then 001, with resultRegEn, CEn, ZEn, NEn and selALUsrc=1. Each instruction is 6 cycles; ALUWB has selData=01.
- STA with opcode driven to 111 during FETCH2: sequence continues RDAC (dataRegEn), then MEMWR (mw, selAddress=1). No HALT entry; mr=0 in MEMWR.
- SDI, then MOVR, then NOP:
  - SDI: DIEn in DECODE, 2 cycles total.
  - MOVR: selAddressAC=01 then 10, resultRegEn then enb, 3 cycles total.
  - NOP: 2 cycles with no strobes except FETCH1's.
- HLT: halted=1 from cycle 3 and stays for 20+ cycles with all strobes 0 and opcode toggling. Asserting reset for one cycle returns the unit to FETCH1 with halted=0.
- Reset asserted in the ALU cycle of ADDA: the following cycle is FETCH1. No enb is issued for the aborted instruction, and op_q reads 000.
